// File: rtl/rtc_pkg.sv
// rtc_pkg: definitions shared by the RTC field editors and the alarm editor.
//   - edit_state_e : state encoding of the field-edit FSM
//   - RTC_ADDR_*   : RTC register address of each time/date field
//   - *_MIN/*_MAX  : legal packed-BCD range of each field
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADDR,
    ST_REL,
    ST_DATA,
    ST_DONE
  } edit_state_e;

  localparam logic [7:0] RTC_ADDR_SEC   = 8'h20;
  localparam logic [7:0] RTC_ADDR_MIN   = 8'h21;
  localparam logic [7:0] RTC_ADDR_HOUR  = 8'h22;
  localparam logic [7:0] RTC_ADDR_DAY   = 8'h24;
  localparam logic [7:0] RTC_ADDR_MONTH = 8'h25;
  localparam logic [7:0] RTC_ADDR_YEAR  = 8'h26;

  localparam logic [7:0] SEC_MIN   = 8'h00;
  localparam logic [7:0] SEC_MAX   = 8'h59;
  localparam logic [7:0] MIN_MIN   = 8'h00;
  localparam logic [7:0] MIN_MAX   = 8'h59;
  localparam logic [7:0] HOUR_MIN  = 8'h00;
  localparam logic [7:0] HOUR_MAX  = 8'h23;
  localparam logic [7:0] DAY_MIN   = 8'h01;
  localparam logic [7:0] DAY_MAX   = 8'h31;
  localparam logic [7:0] MONTH_MIN = 8'h01;
  localparam logic [7:0] MONTH_MAX = 8'h12;
  localparam logic [7:0] YEAR_MIN  = 8'h00;
  localparam logic [7:0] YEAR_MAX  = 8'h99;

endpackage

// File: rtl/bcd_step.sv
// bcd_step: combinational +/-1 step of a field value with wrap-around.
//   val      : current value (packed BCD when bcd_mode=1, else binary)
//   dir      : 1 = increment, 0 = decrement
//   min_val  : lowest legal value
//   max_val  : highest legal value
//   bcd_mode : 1 = packed-BCD arithmetic, 0 = binary
//   next_val : stepped value; an illegal val snaps to min_val (up) or max_val (down)
module bcd_step (
  input  logic [7:0] val,
  input  logic       dir,
  input  logic [7:0] min_val,
  input  logic [7:0] max_val,
  input  logic       bcd_mode,
  output logic [7:0] next_val
);

  logic nib_bad;
  logic illegal;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    next_val = val;
    nib_bad  = bcd_mode && ((val[3:0] > 4'd9) || (val[7:4] > 4'd9));
    illegal  = nib_bad || (val < min_val) || (val > max_val);

    if (illegal) begin
      next_val = dir ? min_val : max_val;
    end else if (dir) begin
      if (val == max_val)
        next_val = min_val;
      else if (bcd_mode && (val[3:0] == 4'd9))
        next_val = {val[7:4] + 4'd1, 4'd0};  // decimal carry into tens digit
      else
        next_val = val + 8'd1;
    end else begin
      if (val == min_val)
        next_val = max_val;
      else if (bcd_mode && (val[3:0] == 4'd0))
        next_val = {val[7:4] - 4'd1, 4'd9};  // decimal borrow from tens digit
      else
        next_val = val - 8'd1;
    end
  end

endmodule

// File: rtl/rtc_field_editor.sv
// rtc_field_editor: user-edit engine for one RTC time/date field.
// An up/down pulse steps the field value and writes it to the RTC with a
// two-phase (address, then data) req/ack write.
//   clk, reset            : clock, asynchronous active-high reset
//   enable                : field selected; low aborts to IDLE on the next edge
//   up, down              : one-cycle step requests (both high = ignored)
//   cur_val               : current field value read back from the RTC
//   bus_ack               : bus master accepted the current phase
//   bus_req/ad/wr/data    : phase request, phase select (0 addr/1 data), write, payload
//   new_val               : last computed value
//   busy, done, err_tmo   : not-idle, data-phase-acked pulse, sticky ack timeout
module rtc_field_editor
  import rtc_pkg::*;
#(
  parameter logic [7:0]  FIELD_ADDR = RTC_ADDR_MONTH,
  parameter logic [7:0]  MIN_VAL    = MONTH_MIN,
  parameter logic [7:0]  MAX_VAL    = MONTH_MAX,
  parameter bit          BCD_MODE   = 1'b1,
  parameter int unsigned ACK_TMO    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       up,
  input  logic       down,
  input  logic [7:0] cur_val,
  input  logic       bus_ack,
  output logic       bus_req,
  output logic       bus_ad,
  output logic       bus_wr,
  output logic [7:0] bus_data,
  output logic [7:0] new_val,
  output logic       busy,
  output logic       done,
  output logic       err_tmo
);

  // Timeout fires on the edge that would complete the ACK_TMO-th waiting cycle.
  localparam logic [7:0] TMO_LAST = 8'(ACK_TMO - 1);

  edit_state_e state;
  logic [7:0]  cap_val;
  logic        cap_up;
  logic [7:0]  tmo_cnt;
  logic [7:0]  step_val;

  bcd_step u_step (
    .val      (cap_val),
    .dir      (cap_up),
    .min_val  (MIN_VAL),
    .max_val  (MAX_VAL),
    .bcd_mode (BCD_MODE),
    .next_val (step_val)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cap_val  <= '0;
      cap_up   <= 1'b0;
      tmo_cnt  <= '0;
      bus_req  <= 1'b0;
      bus_ad   <= 1'b0;
      bus_wr   <= 1'b0;
      bus_data <= '0;
      new_val  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_tmo  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!enable && (state != ST_IDLE)) begin
        // Abort: release the bus at once; new_val and err_tmo are kept.
        state    <= ST_IDLE;
        bus_req  <= 1'b0;
        bus_ad   <= 1'b0;
        bus_wr   <= 1'b0;
        bus_data <= '0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (enable && (up ^ down)) begin
              cap_val <= cur_val;
              cap_up  <= up;
              err_tmo <= 1'b0;
              busy    <= 1'b1;
              state   <= ST_CALC;
            end
          end
          ST_CALC: begin
            new_val  <= step_val;
            bus_req  <= 1'b1;
            bus_wr   <= 1'b1;
            bus_ad   <= 1'b0;
            bus_data <= FIELD_ADDR;
            tmo_cnt  <= '0;
            state    <= ST_ADDR;
          end
          ST_ADDR, ST_DATA: begin
            if (bus_ack) begin
              bus_req  <= 1'b0;
              bus_wr   <= 1'b0;
              bus_ad   <= 1'b0;
              bus_data <= '0;
              if (state == ST_DATA) begin
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                state <= ST_REL;
              end
            end else if (tmo_cnt == TMO_LAST) begin
              bus_req  <= 1'b0;
              bus_wr   <= 1'b0;
              bus_ad   <= 1'b0;
              bus_data <= '0;
              busy     <= 1'b0;
              err_tmo  <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
          ST_REL: begin
            // One cycle with bus_req low separates the two phases.
            bus_req  <= 1'b1;
            bus_wr   <= 1'b1;
            bus_ad   <= 1'b1;
            bus_data <= new_val;
            tmo_cnt  <= '0;
            state    <= ST_DATA;
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rtc_field_editor.sv
// Self-checking bench for rtc_field_editor configured as the month field
// (01..12 BCD, address 8'h25) with a 4-cycle ack timeout.
module tb_rtc_field_editor;

  localparam int         TMO     = 4;
  localparam logic [7:0] ADDR    = 8'h25;
  localparam int         MIN_DEC = 1;
  localparam int         MAX_DEC = 12;

  logic       clk = 1'b0;
  logic       reset, enable, up, down, bus_ack;
  logic [7:0] cur_val;
  logic       bus_req, bus_ad, bus_wr, busy, done, err_tmo;
  logic [7:0] bus_data, new_val;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  rtc_field_editor #(
    .FIELD_ADDR (8'h25),
    .MIN_VAL    (8'h01),
    .MAX_VAL    (8'h12),
    .BCD_MODE   (1'b1),
    .ACK_TMO    (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .up       (up),
    .down     (down),
    .cur_val  (cur_val),
    .bus_ack  (bus_ack),
    .bus_req  (bus_req),
    .bus_ad   (bus_ad),
    .bus_wr   (bus_wr),
    .bus_data (bus_data),
    .new_val  (new_val),
    .busy     (busy),
    .done     (done),
    .err_tmo  (err_tmo)
  );

  typedef struct {
    logic       u;
    logic       d;
    logic [7:0] cv;
    logic [7:0] exp_val;
  } vec_t;

  typedef struct {
    int         req_first, done_first, busy_low, done_cnt, addr_hi, data_hi, wr_bad;
    logic [7:0] addr_data, data_data;
    bit         gap_ok, ended;
    logic       err_at1, drop_req, drop_busy;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference step: decimal arithmetic on the decoded month number.
  function automatic logic [7:0] ref_step(input logic [7:0] v, input bit is_up);
    int hi, lo, n;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    n  = hi * 10 + lo;
    if (hi > 9 || lo > 9 || n < MIN_DEC || n > MAX_DEC)
      n = is_up ? MIN_DEC : MAX_DEC;
    else if (is_up)
      n = (n == MAX_DEC) ? MIN_DEC : n + 1;
    else
      n = (n == MIN_DEC) ? MAX_DEC : n - 1;
    return 8'(((n / 10) << 4) + (n % 10));
  endfunction

  // Issue one edit request and follow it cycle by cycle (bounded), acting as
  // the bus master. addr_dly/data_dly: request cycles seen before acking.
  task automatic run_edit(input logic u, input logic d, input logic [7:0] cv,
                          input int addr_dly, input int data_dly,
                          input bit drop_in_data, input int extra_k, output res_t r);
    int addr_w, data_w, drop_k;
    bit saw_rel, addr_seen, data_seen, busy_seen;
    r = '{default: 0};
    addr_w = 0; data_w = 0; drop_k = -10;
    saw_rel = 0; addr_seen = 0; data_seen = 0; busy_seen = 0;
    @(posedge clk); #1 cur_val = cv; up = u; down = d;
    @(posedge clk); #1 up = 1'b0; down = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (k == 1) r.err_at1 = err_tmo;
      if (bus_wr !== bus_req) r.wr_bad++;
      if (busy) busy_seen = 1;
      if (bus_req && r.req_first == 0) r.req_first = k;
      if (done) begin
        r.done_cnt++;
        if (r.done_first == 0) r.done_first = k;
      end
      if (k == drop_k + 1) begin
        r.drop_req  = bus_req;
        r.drop_busy = busy;
        enable = 1'b1;
      end
      if (bus_req && !bus_ad) begin
        if (!addr_seen) r.addr_data = bus_data;
        addr_seen = 1;
        r.addr_hi++;
        addr_w++;
        if (addr_w > addr_dly) bus_ack = 1'b1;
      end
      if (!bus_req && addr_seen) saw_rel = 1;
      if (bus_req && bus_ad) begin
        if (!data_seen) begin
          r.data_data = bus_data;
          r.gap_ok    = saw_rel;
        end
        data_seen = 1;
        r.data_hi++;
        data_w++;
        if (drop_in_data && drop_k < 0) begin
          enable = 1'b0;
          drop_k = k;
        end else if (data_w > data_dly) begin
          bus_ack = 1'b1;
        end
      end
      if (k == extra_k) begin
        up = 1'b1;
        cur_val = 8'h05;
      end
      if (k == extra_k + 1) up = 1'b0;
      if (busy_seen && !busy && k > 1) begin
        r.busy_low = k;
        r.ended    = 1;
        break;
      end
    end
    bus_ack = 1'b0;
    enable  = 1'b1;
    up      = 1'b0;
  endtask

  vec_t       vecs[12];
  res_t       r;
  logic [7:0] last_exp;
  logic [7:0] exp_v;
  int         bad;
  bit         found;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'h09, 8'h10};
    vecs[1]  = '{1'b1, 1'b0, 8'h12, 8'h01};
    vecs[2]  = '{1'b0, 1'b1, 8'h01, 8'h12};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 8'h01};
    vecs[4]  = '{1'b1, 1'b0, 8'h1A, 8'h01};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h12};
    vecs[6]  = '{1'b0, 1'b1, 8'h1A, 8'h12};
    vecs[7]  = '{1'b0, 1'b1, 8'h10, 8'h09};
    vecs[8]  = '{1'b1, 1'b0, 8'h11, 8'h12};
    vecs[9]  = '{1'b0, 1'b1, 8'h05, 8'h04};
    vecs[10] = '{1'b1, 1'b0, 8'h99, 8'h01};
    vecs[11] = '{1'b0, 1'b1, 8'hF0, 8'h12};

    reset = 1'b1; enable = 1'b1; up = 1'b0; down = 1'b0; bus_ack = 1'b0; cur_val = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({bus_req, bus_ad, bus_wr, bus_data, new_val, busy, done, err_tmo}), 0);
    reset = 1'b0;

    // Minimum-latency transaction with immediate acks.
    run_edit(1'b1, 1'b0, 8'h09, 0, 0, 1'b0, 0, r);
    check("lat_ended", 32'(r.ended), 1);
    check("lat_req_first", r.req_first, 2);
    check("lat_done_cycle", r.done_first, 5);
    check("lat_total", r.busy_low, 6);

    foreach (vecs[i]) begin
      run_edit(vecs[i].u, vecs[i].d, vecs[i].cv, 1, 1, 1'b0, 0, r);
      check($sformatf("vec%0d_ended", i), 32'(r.ended), 1);
      check($sformatf("vec%0d_new_val", i), 32'(new_val), 32'(vecs[i].exp_val));
      check($sformatf("vec%0d_addr_data", i), 32'(r.addr_data), 32'(ADDR));
      check($sformatf("vec%0d_data_data", i), 32'(r.data_data), 32'(vecs[i].exp_val));
      check($sformatf("vec%0d_done_cnt", i), r.done_cnt, 1);
      check($sformatf("vec%0d_gap", i), 32'(r.gap_ok), 1);
      check($sformatf("vec%0d_wr", i), r.wr_bad, 0);
      check($sformatf("vec%0d_err", i), 32'(err_tmo), 0);
    end

    // Address-phase timeout.
    run_edit(1'b1, 1'b0, 8'h03, 1000, 1000, 1'b0, 0, r);
    check("tmo_addr_ended", 32'(r.ended), 1);
    check("tmo_addr_req_cycles", r.addr_hi, TMO);
    check("tmo_addr_no_data", r.data_hi, 0);
    check("tmo_addr_err", 32'(err_tmo), 1);
    check("tmo_addr_done", r.done_cnt, 0);
    check("tmo_addr_req_low", 32'(bus_req), 0);
    check("tmo_addr_new_val", 32'(new_val), 32'h04);

    // The next accepted edit clears err_tmo.
    run_edit(1'b1, 1'b0, 8'h04, 1, 1, 1'b0, 0, r);
    check("err_clear_at_accept", 32'(r.err_at1), 0);
    check("err_clear_new_val", 32'(new_val), 32'h05);
    check("err_clear_done", r.done_cnt, 1);

    // Data-phase timeout.
    run_edit(1'b0, 1'b1, 8'h06, 0, 1000, 1'b0, 0, r);
    check("tmo_data_req_cycles", r.data_hi, TMO);
    check("tmo_data_err", 32'(err_tmo), 1);
    check("tmo_data_done", r.done_cnt, 0);
    check("tmo_data_new_val", 32'(new_val), 32'h05);

    // enable dropped during the data phase.
    run_edit(1'b1, 1'b0, 8'h07, 0, 0, 1'b1, 0, r);
    check("drop_ended", 32'(r.ended), 1);
    check("drop_req", 32'(r.drop_req), 0);
    check("drop_busy", 32'(r.drop_busy), 0);
    check("drop_done", r.done_cnt, 0);
    check("drop_new_val", 32'(new_val), 32'h08);
    check("drop_err", 32'(err_tmo), 0);
    last_exp = 8'h08;

    // up and down together: ignored.
    @(posedge clk); #1 cur_val = 8'h03; up = 1'b1; down = 1'b1;
    @(posedge clk); #1 up = 1'b0; down = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy || bus_req) bad++;
    end
    check("both_idle", bad, 0);
    check("both_new_val", 32'(new_val), 32'(last_exp));

    // up pulsed while busy: ignored, only one transaction.
    run_edit(1'b1, 1'b0, 8'h08, 1, 1, 1'b0, 3, r);
    check("busy_pulse_done", r.done_cnt, 1);
    check("busy_pulse_new_val", 32'(new_val), 32'h09);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy || bus_req) bad++;
    end
    check("busy_pulse_no_restart", bad, 0);

    // Randomised edits against the reference step.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] cv;
      bit         dir_up;
      int         n;
      n  = int'($urandom_range(1, 12));
      cv = ($urandom_range(0, 1) == 1) ? 8'(((n / 10) << 4) + (n % 10)) : 8'($urandom_range(0, 255));
      dir_up = ($urandom_range(0, 1) == 1);
      exp_v  = ref_step(cv, dir_up);
      run_edit(dir_up, !dir_up, cv, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, 0, r);
      check($sformatf("rand%0d_new_val", i), 32'(new_val), 32'(exp_v));
      check($sformatf("rand%0d_data", i), 32'(r.data_data), 32'(exp_v));
      check($sformatf("rand%0d_done", i), r.done_cnt, 1);
    end

    // Asynchronous reset while the address phase is pending.
    @(posedge clk); #1 cur_val = 8'h03; up = 1'b1;
    @(posedge clk); #1 up = 1'b0;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus_req) begin
        found = 1;
        break;
      end
    end
    check("rst_reach_addr", 32'(found), 1);
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", 32'({bus_req, bus_ad, bus_wr, bus_data, new_val, busy, done, err_tmo}), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_after_req", 32'({bus_req, busy}), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
